// File: rtl/mac_pe.sv
// rtl/mac_pe.sv - multiply-accumulate PE with operand forwarding and result handshake
module mac_pe #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 20,
  parameter int OUT_W    = 8,
  parameter bit SIGNED   = 1'b0,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              last,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              fwd_valid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  result,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, FULL} state_t;

  state_t                state;
  logic [ACC_W-1:0]      acc;
  logic                  acc_ovf;

  logic                  take;
  logic                  finish;
  logic                  slot_free;
  logic                  load_res;

  logic [2*DATA_W-1:0]   prod_s;
  logic [2*DATA_W-1:0]   prod_u;
  logic [ACC_W:0]        prod_x;
  logic [ACC_W:0]        base_x;
  logic [ACC_W:0]        sum_x;
  logic                  add_ovf;
  logic [ACC_W-1:0]      sum_val;
  logic                  sum_ovf;

  logic [ACC_W-1:0]      nar_src;
  logic [ACC_W-1:0]      nar_shift;
  logic [ACC_W-1:0]      nar_sshift;
  logic                  in_range;
  logic [OUT_W-1:0]      nar_val;
  logic                  nar_ovf;

  // A finished sum parked in acc blocks new terms until the result slot frees up
  assign in_ready  = (state != FULL);
  assign take      = in_valid && in_ready;
  assign finish    = take && last;
  assign slot_free = !res_valid || res_ready;
  assign load_res  = (finish && slot_free) || ((state == FULL) && res_ready);

  // Product and running sum, computed one bit wider than acc to catch overflow
  always_comb begin
    // Operands extended to full product width so the truncated product is exact for both signednesses
    prod_s = {{DATA_W{a_in[DATA_W-1]}}, a_in} * {{DATA_W{b_in[DATA_W-1]}}, b_in};
    prod_u = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
    if (SIGNED) prod_x = {{(ACC_W-2*DATA_W+2){prod_s[2*DATA_W-1]}}, prod_s[2*DATA_W-2:0]};
    else        prod_x = {{(ACC_W-2*DATA_W+1){1'b0}}, prod_u};

    if (state == IDLE)  base_x = '0;
    else if (SIGNED)    base_x = {acc[ACC_W-1], acc};
    else                base_x = {1'b0, acc};

    sum_x   = base_x + prod_x;
    add_ovf = SIGNED ? (sum_x[ACC_W] ^ sum_x[ACC_W-1]) : sum_x[ACC_W];

    sum_val = sum_x[ACC_W-1:0];
    sum_ovf = 1'b0;
    if (SATURATE && add_ovf) begin
      sum_ovf = 1'b1;
      if (!SIGNED)           sum_val = '1;
      else if (sum_x[ACC_W]) sum_val = {1'b1, {(ACC_W-1){1'b0}}};
      else                   sum_val = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Narrow the finished sum to OUT_W; source is acc when draining FULL, else the live sum
  always_comb begin
    nar_src    = (state == FULL) ? acc : sum_val;
    nar_shift  = nar_src >> OUT_W;
    nar_sshift = $signed(nar_src) >>> (OUT_W - 1);
    if (SIGNED) in_range = (nar_sshift == '0) || (nar_sshift == '1);
    else        in_range = (nar_shift == '0);

    nar_val = nar_src[OUT_W-1:0];
    if (SATURATE && !in_range) begin
      if (!SIGNED)              nar_val = '1;
      else if (nar_src[ACC_W-1]) nar_val = {1'b1, {(OUT_W-1){1'b0}}};
      else                       nar_val = {1'b0, {(OUT_W-1){1'b1}}};
    end
    nar_ovf = ((state == FULL) ? acc_ovf : (acc_ovf | sum_ovf)) | !in_range;
  end

  // Accumulator state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (take) begin
            if (!last) begin
              acc     <= sum_val;
              acc_ovf <= acc_ovf | sum_ovf;
              state   <= ACCUM;
            end else if (slot_free) begin
              acc     <= '0;
              acc_ovf <= 1'b0;
              state   <= IDLE;
            end else begin
              acc     <= sum_val;
              acc_ovf <= acc_ovf | sum_ovf;
              state   <= FULL;
            end
          end
        end
        FULL: begin
          if (res_ready) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          acc     <= '0;
          acc_ovf <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Result register: a reload in the same cycle as a drain keeps res_valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
    end else if (load_res) begin
      res_valid <= 1'b1;
      result    <= nar_val;
      ovf       <= nar_ovf;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Operand forwarding to neighbours, updated only on accepted terms
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= '0;
      b_out     <= '0;
      fwd_valid <= 1'b0;
    end else begin
      fwd_valid <= take;
      if (take) begin
        a_out <= a_in;
        b_out <= b_in;
      end
    end
  end

endmodule

// File: tb/tb_mac_pe.sv
// tb/tb_mac_pe.sv - randomized self-checking bench for mac_pe across signedness/saturation variants
module tb_mac_pe;

  localparam bit SGN [3] = '{1'b0, 1'b0, 1'b1};
  localparam bit SAT [3] = '{1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       last = 1'b0;
  logic       res_ready = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;

  logic       in_rdy [3];
  logic       fwd_v  [3];
  logic       res_v  [3];
  logic       ovf_o  [3];
  logic [7:0] a_o    [3];
  logic [7:0] b_o    [3];
  logic [7:0] res_o  [3];

  int n_vec = 0;
  int n_fail = 0;
  int run_a[$];
  int run_b[$];
  logic [7:0] er;
  logic       eo;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mac_pe #(.DATA_W(8), .ACC_W(20), .OUT_W(8), .SIGNED(SGN[g]), .SATURATE(SAT[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[g]),
      .a_in(a_in), .b_in(b_in), .last(last),
      .a_out(a_o[g]), .b_out(b_o[g]), .fwd_valid(fwd_v[g]),
      .res_valid(res_v[g]), .res_ready(res_ready), .result(res_o[g]), .ovf(ovf_o[g])
    );
  end

  // Reference: dot product in wide integer arithmetic, clamped or wrapped per variant
  function automatic void model(input int k, output logic [7:0] r, output logic o);
    longint acc = 0;
    longint x, y, lo, hi, olo, ohi;
    bit flag = 1'b0;
    bit out_of_range;
    lo  = SGN[k] ? -524288 : 0;
    hi  = SGN[k] ? 524287 : 1048575;
    olo = SGN[k] ? -128 : 0;
    ohi = SGN[k] ? 127 : 255;
    foreach (run_a[i]) begin
      x = run_a[i];
      y = run_b[i];
      if (SGN[k] && x >= 128) x -= 256;
      if (SGN[k] && y >= 128) y -= 256;
      acc += x * y;
      if (SAT[k]) begin
        if (acc > hi) begin acc = hi; flag = 1'b1; end
        else if (acc < lo) begin acc = lo; flag = 1'b1; end
      end else begin
        acc = acc % 1048576;
        if (acc < 0) acc += 1048576;
        if (SGN[k] && acc >= 524288) acc -= 1048576;
      end
    end
    out_of_range = (acc < olo) || (acc > ohi);
    if (SAT[k] && out_of_range) acc = (acc < olo) ? olo : ohi;
    r = acc[7:0];
    o = flag | out_of_range;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one term, wait (bounded) for in_ready, let it be taken, then drop in_valid
  task automatic send(input int a, input int b, input bit l);
    int w = 0;
    in_valid = 1'b1;
    a_in = a[7:0];
    b_in = b[7:0];
    last = l;
    while (in_rdy[0] !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    if (w == 20) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got %b, expected 1 within 20 cycles", in_rdy[0]);
    end
    step();
    in_valid = 1'b0;
    last = 1'b0;
    run_a.push_back(a);
    run_b.push_back(b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({a_o[k], b_o[k], fwd_v[k], res_v[k], res_o[k], ovf_o[k]} !== '0 || in_rdy[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got a=%h b=%h fv=%b rv=%b res=%h ovf=%b rdy=%b, expected zeros and rdy=1",
                 k, a_o[k], b_o[k], fwd_v[k], res_v[k], res_o[k], ovf_o[k], in_rdy[k]);
      end
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    res_ready = 1'b1;
    run_a.delete(); run_b.delete();
    send(3, 4, 0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (a_o[k] !== 8'd3 || b_o[k] !== 8'd4 || fwd_v[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL fwd_first dut%0d: got a=%h b=%h fv=%b, expected a=03 b=04 fv=1", k, a_o[k], b_o[k], fwd_v[k]);
      end
    end
    send(5, 6, 0);
    send(2, 7, 1);
    for (int k = 0; k < 3; k++) begin
      model(k, er, eo);
      n_vec++;
      if (res_v[k] !== 1'b1 || res_o[k] !== er || ovf_o[k] !== eo || a_o[k] !== 8'd2 || b_o[k] !== 8'd7) begin
        n_fail++;
        $display("FAIL basic_result dut%0d: got rv=%b res=%h ovf=%b a=%h b=%h, expected rv=1 res=%h ovf=%b a=02 b=07",
                 k, res_v[k], res_o[k], ovf_o[k], a_o[k], b_o[k], er, eo);
      end
    end
    n_vec++;
    if (res_o[0] !== 8'd56) begin
      n_fail++;
      $display("FAIL basic_value: got %0d, expected 56", res_o[0]);
    end
    step();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (res_v[k] !== 1'b0 || fwd_v[k] !== 1'b0 || a_o[k] !== 8'd2) begin
        n_fail++;
        $display("FAIL basic_drain dut%0d: got rv=%b fv=%b a=%h, expected rv=0 fv=0 a=02", k, res_v[k], fwd_v[k], a_o[k]);
      end
    end
  endtask

  task automatic test_saturation();
    res_ready = 1'b1;
    run_a.delete(); run_b.delete();
    send(200, 200, 0);
    send(100, 100, 1);
    for (int k = 0; k < 3; k++) begin
      model(k, er, eo);
      n_vec++;
      if (res_v[k] !== 1'b1 || res_o[k] !== er || ovf_o[k] !== eo) begin
        n_fail++;
        $display("FAIL sat_result dut%0d: got rv=%b res=%h ovf=%b, expected rv=1 res=%h ovf=%b", k, res_v[k], res_o[k], ovf_o[k], er, eo);
      end
    end
    n_vec++;
    if (res_o[0] !== 8'd255 || res_o[1] !== 8'd80 || ovf_o[0] !== 1'b1 || ovf_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_values: got sat=%0d/%b wrap=%0d/%b, expected 255/1 and 80/1", res_o[0], ovf_o[0], res_o[1], ovf_o[1]);
    end
    step();
  endtask

  task automatic test_signed();
    res_ready = 1'b1;
    run_a.delete(); run_b.delete();
    send(8'hFD, 5, 0);
    send(2, 8'hFC, 1);
    for (int k = 0; k < 3; k++) begin
      model(k, er, eo);
      n_vec++;
      if (res_o[k] !== er || ovf_o[k] !== eo) begin
        n_fail++;
        $display("FAIL signed_small dut%0d: got res=%h ovf=%b, expected res=%h ovf=%b", k, res_o[k], ovf_o[k], er, eo);
      end
    end
    n_vec++;
    if (res_o[2] !== 8'hE9 || ovf_o[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL signed_value: got %h/%b, expected e9/0", res_o[2], ovf_o[2]);
    end
    run_a.delete(); run_b.delete();
    send(8'h80, 8'h80, 0);
    send(8'h80, 8'h80, 1);
    for (int k = 0; k < 3; k++) begin
      model(k, er, eo);
      n_vec++;
      if (res_o[k] !== er || ovf_o[k] !== eo) begin
        n_fail++;
        $display("FAIL signed_clamp dut%0d: got res=%h ovf=%b, expected res=%h ovf=%b", k, res_o[k], ovf_o[k], er, eo);
      end
    end
    n_vec++;
    if (res_o[2] !== 8'd127 || ovf_o[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL signed_clamp_value: got %h/%b, expected 7f/1", res_o[2], ovf_o[2]);
    end
    step();
  endtask

  // Drive the accumulator past its own range, then back down so only the sticky flag remembers
  task automatic test_acc_saturation();
    res_ready = 1'b1;
    run_a.delete(); run_b.delete();
    for (int i = 0; i < 33; i++) send(8'h80, 8'h80, 0);
    for (int i = 0; i < 32; i++) send(127, 8'h80, 0);
    send(45, 165, 1);
    for (int k = 0; k < 3; k++) begin
      model(k, er, eo);
      n_vec++;
      if (res_o[k] !== er || ovf_o[k] !== eo) begin
        n_fail++;
        $display("FAIL acc_sat dut%0d: got res=%h ovf=%b, expected res=%h ovf=%b", k, res_o[k], ovf_o[k], er, eo);
      end
    end
    n_vec++;
    if (res_o[2] !== 8'd0 || ovf_o[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL acc_sat_sticky: got %h/%b, expected 00/1", res_o[2], ovf_o[2]);
    end
    step();
  endtask

  task automatic test_backpressure();
    res_ready = 1'b1;
    run_a.delete(); run_b.delete();
    send(2, 5, 1);
    n_vec++;
    if (res_v[0] !== 1'b1 || res_o[0] !== 8'd10) begin
      n_fail++;
      $display("FAIL bp_first: got rv=%b res=%0d, expected rv=1 res=10", res_v[0], res_o[0]);
    end
    res_ready = 1'b0;
    run_a.delete(); run_b.delete();
    send(1, 1, 0);
    send(1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (in_rdy[k] !== 1'b0 || res_v[k] !== 1'b1 || res_o[k] !== 8'd10) begin
        n_fail++;
        $display("FAIL bp_full dut%0d: got rdy=%b rv=%b res=%0d, expected rdy=0 rv=1 res=10", k, in_rdy[k], res_v[k], res_o[k]);
      end
    end
    in_valid = 1'b1; a_in = 8'd7; b_in = 8'd7; last = 1'b1;
    repeat (3) begin
      step();
      n_vec++;
      if (fwd_v[0] !== 1'b0 || in_rdy[0] !== 1'b0 || res_o[0] !== 8'd10) begin
        n_fail++;
        $display("FAIL bp_ignored: got fv=%b rdy=%b res=%0d, expected fv=0 rdy=0 res=10", fwd_v[0], in_rdy[0], res_o[0]);
      end
    end
    in_valid = 1'b0; last = 1'b0;
    res_ready = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (res_o[k] !== 8'd2 || res_v[k] !== 1'b1 || in_rdy[k] !== 1'b1 || ovf_o[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_release dut%0d: got res=%0d rv=%b rdy=%b ovf=%b, expected res=2 rv=1 rdy=1 ovf=0",
                 k, res_o[k], res_v[k], in_rdy[k], ovf_o[k]);
      end
    end
    step();
    n_vec++;
    if (res_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got rv=%b, expected 0", res_v[0]);
    end
    run_a.delete(); run_b.delete();
    send(1, 3, 1);
    n_vec++;
    if (res_o[0] !== 8'd3 || res_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_after: got res=%0d rv=%b, expected res=3 rv=1", res_o[0], res_v[0]);
    end
    step();
  endtask

  task automatic test_async_reset();
    res_ready = 1'b0;
    run_a.delete(); run_b.delete();
    send(3, 3, 1);
    send(9, 9, 0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({a_o[k], b_o[k], fwd_v[k], res_v[k], res_o[k], ovf_o[k]} !== '0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: got a=%h b=%h fv=%b rv=%b res=%h ovf=%b, expected all zero",
                 k, a_o[k], b_o[k], fwd_v[k], res_v[k], res_o[k], ovf_o[k]);
      end
    end
    #2;
    rst_n = 1'b1;
    res_ready = 1'b1;
    run_a.delete(); run_b.delete();
    send(1, 2, 1);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (res_v[k] !== 1'b1 || res_o[k] !== 8'd2 || ovf_o[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset dut%0d: got rv=%b res=%0d ovf=%b, expected rv=1 res=2 ovf=0", k, res_v[k], res_o[k], ovf_o[k]);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b1;
    run_a.delete(); run_b.delete();
    send(2, 3, 0);
    send(2, 3, 1);
    n_vec++;
    if (res_v[0] !== 1'b1 || res_o[0] !== 8'd12) begin
      n_fail++;
      $display("FAIL b2b_first: got rv=%b res=%0d, expected rv=1 res=12", res_v[0], res_o[0]);
    end
    run_a.delete(); run_b.delete();
    send(4, 5, 1);
    n_vec++;
    if (res_v[0] !== 1'b1 || res_o[0] !== 8'd20) begin
      n_fail++;
      $display("FAIL b2b_second: got rv=%b res=%0d, expected rv=1 res=20", res_v[0], res_o[0]);
    end
    step();
  endtask

  task automatic test_random();
    int len;
    res_ready = 1'b1;
    for (int r = 0; r < 30; r++) begin
      run_a.delete(); run_b.delete();
      len = $urandom_range(1, 5);
      for (int t = 0; t < len; t++) begin
        repeat ($urandom_range(0, 2)) step();
        send($urandom_range(0, 255), $urandom_range(0, 255), t == len - 1);
      end
      for (int k = 0; k < 3; k++) begin
        model(k, er, eo);
        n_vec++;
        if (res_v[k] !== 1'b1 || res_o[k] !== er || ovf_o[k] !== eo) begin
          n_fail++;
          $display("FAIL random run%0d dut%0d: got rv=%b res=%h ovf=%b, expected rv=1 res=%h ovf=%b",
                   r, k, res_v[k], res_o[k], ovf_o[k], er, eo);
        end
      end
    end
    step();
  endtask

  // Random valid and ready at cycle level; expected results queued at the last take, popped at each handshake
  task automatic test_random_backpressure();
    localparam int N = 60;
    int ta[N];
    int tb[N];
    bit tl[N];
    logic [26:0] expq[$];
    logic [26:0] e;
    int idx = 0;
    int cyc = 0;
    for (int i = 0; i < N; i++) begin
      ta[i] = $urandom_range(0, 255);
      tb[i] = $urandom_range(0, 255);
      tl[i] = ($urandom_range(0, 2) == 0) || (i == N - 1);
    end
    run_a.delete(); run_b.delete();
    while ((idx < N || expq.size() > 0) && cyc < 2000) begin
      res_ready = (idx >= N) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (idx < N && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; a_in = ta[idx][7:0]; b_in = tb[idx][7:0]; last = tl[idx];
      end else begin
        in_valid = 1'b0; last = 1'b0;
      end
      if (res_v[0] === 1'b1 && res_ready) begin
        n_vec++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL rbp_unexpected: got result %h with no run finished, expected none", res_o[0]);
        end else begin
          e = expq.pop_front();
          if ({ovf_o[2], res_o[2], ovf_o[1], res_o[1], ovf_o[0], res_o[0]} !== e) begin
            n_fail++;
            $display("FAIL rbp_result cycle%0d: got %h, expected %h", cyc,
                     {ovf_o[2], res_o[2], ovf_o[1], res_o[1], ovf_o[0], res_o[0]}, e);
          end
        end
      end
      if (in_valid && in_rdy[0] === 1'b1) begin
        run_a.push_back(ta[idx]);
        run_b.push_back(tb[idx]);
        if (tl[idx]) begin
          e = '0;
          for (int k = 0; k < 3; k++) begin
            model(k, er, eo);
            e[k*9 +: 9] = {eo, er};
          end
          expq.push_back(e);
          run_a.delete(); run_b.delete();
        end
        idx++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; last = 1'b0;
    if (cyc >= 2000) begin
      n_vec++;
      n_fail++;
      $display("FAIL rbp_timeout: got %0d terms taken and %0d results pending, expected %0d and 0", idx, expq.size(), N);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_signed();
    test_acc_saturation();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    test_random();
    test_random_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
